// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the partitioned 4-way cache.
package cache_pkg;

    localparam int unsigned WAY_NUM      = 4;
    localparam int unsigned WAY_NUM_BITS = 2;
    localparam int unsigned CACHE_LINES  = 1024;
    localparam int unsigned INDEX_BITS   = $clog2(CACHE_LINES);

    typedef enum logic [1:0] {
        LRU_INIT   = 2'd0,
        LRU_IDLE   = 2'd1,
        LRU_UPDATE = 2'd2
    } lru_state_t;

endpackage

// File: rtl/cache_lru_next.sv
// Combinational LRU update: picks the accessed way (hit way or masked LRU
// victim) and produces the new age permutation with that way promoted to MRU.
module cache_lru_next
    import cache_pkg::*;
(
    input  logic [WAY_NUM_BITS-1:0] i_ages [0:WAY_NUM-1],
    input  logic                    i_hit,
    input  logic [WAY_NUM_BITS-1:0] i_hit_way,
    input  logic [WAY_NUM-1:0]      i_mask,
    output logic [WAY_NUM_BITS-1:0] o_way,
    output logic                    o_no_way,
    output logic [WAY_NUM_BITS-1:0] o_ages [0:WAY_NUM-1]
);

    logic                    w_found;
    logic [WAY_NUM_BITS-1:0] w_victim;
    logic [WAY_NUM_BITS-1:0] w_victim_age;
    logic [WAY_NUM_BITS-1:0] w_acc_age;

    // Oldest way among the candidates in the mask; ages are unique so no tie-break.
    always_comb begin
        w_found      = 1'b0;
        w_victim     = '0;
        w_victim_age = '0;
        for (int i = 0; i < WAY_NUM; i++) begin
            if (i_mask[i] && (!w_found || (i_ages[i] > w_victim_age))) begin
                w_found      = 1'b1;
                w_victim     = WAY_NUM_BITS'(i);
                w_victim_age = i_ages[i];
            end
        end
    end

    // Hit way wins outright; a miss with an empty mask has no way to return.
    always_comb begin
        o_no_way = 1'b0;
        o_way    = '0;
        if (i_hit) begin
            o_way = i_hit_way;
        end else if (w_found) begin
            o_way = w_victim;
        end else begin
            o_no_way = 1'b1;
        end
    end

    // Promote the accessed way to MRU and age every younger way by one.
    always_comb begin
        w_acc_age = i_ages[o_way];
        for (int i = 0; i < WAY_NUM; i++) begin
            o_ages[i] = i_ages[i];
            if (WAY_NUM_BITS'(i) == o_way) begin
                o_ages[i] = '0;
            end else if (i_ages[i] < w_acc_age) begin
                o_ages[i] = i_ages[i] + WAY_NUM_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/cache_lru_ctrl.sv
// LRU replacement controller: initialises every line to a legal age
// permutation, then serves one lookup per two cycles with a read-modify-write
// of the per-line ages held in the external LRU memory.
module cache_lru_ctrl
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic                    req_hit,
    input  logic [WAY_NUM_BITS-1:0] req_hit_way,
    input  logic [WAY_NUM-1:0]      req_way_mask,
    output logic                    resp_valid,
    output logic [WAY_NUM_BITS-1:0] resp_way,
    output logic                    resp_no_way,
    output logic                    init_done,
    output logic [INDEX_BITS-1:0]   lru_index,
    output logic                    lru_req_we,
    output logic [WAY_NUM_BITS-1:0] lru_write [0:WAY_NUM-1],
    input  logic [WAY_NUM_BITS-1:0] lru_read  [0:WAY_NUM-1]
);

    localparam logic [INDEX_BITS-1:0] LAST_LINE = INDEX_BITS'(CACHE_LINES - 1);

    lru_state_t              r_state;
    logic [INDEX_BITS-1:0]   r_init_cnt;
    logic [INDEX_BITS-1:0]   r_lru_index;
    logic                    r_we;
    logic                    r_ready;
    logic                    r_resp_valid;
    logic                    r_init_done;
    logic                    r_hit;
    logic [WAY_NUM_BITS-1:0] r_hit_way;
    logic [WAY_NUM-1:0]      r_mask;

    logic [WAY_NUM_BITS-1:0] w_way;
    logic                    w_no_way;
    logic [WAY_NUM_BITS-1:0] w_new_ages [0:WAY_NUM-1];

    cache_lru_next u_next (
        .i_ages    (lru_read),
        .i_hit     (r_hit),
        .i_hit_way (r_hit_way),
        .i_mask    (r_mask),
        .o_way     (w_way),
        .o_no_way  (w_no_way),
        .o_ages    (w_new_ages)
    );

    // FSM: init sweep, idle capture, single-cycle update with registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LRU_INIT;
            r_init_cnt   <= '0;
            r_lru_index  <= '0;
            r_we         <= 1'b0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_init_done  <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_way    <= '0;
            r_mask       <= '0;
        end else begin
            case (r_state)
                LRU_INIT: begin
                    // r_we marks that a line is being written this cycle.
                    if (r_we && (r_lru_index == LAST_LINE)) begin
                        r_state     <= LRU_IDLE;
                        r_we        <= 1'b0;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end else begin
                        r_we        <= 1'b1;
                        r_lru_index <= r_init_cnt;
                        r_init_cnt  <= r_init_cnt + INDEX_BITS'(1);
                    end
                end
                LRU_IDLE: begin
                    if (req_valid) begin
                        r_state      <= LRU_UPDATE;
                        r_lru_index  <= req_index;
                        r_hit        <= req_hit;
                        r_hit_way    <= req_hit_way;
                        r_mask       <= req_way_mask;
                        r_we         <= req_hit | (|req_way_mask);
                        r_resp_valid <= 1'b1;
                        r_ready      <= 1'b0;
                    end
                end
                LRU_UPDATE: begin
                    r_state      <= LRU_IDLE;
                    r_we         <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                end
                default: begin
                    r_state <= LRU_INIT;
                    r_we    <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Write data: identity permutation during the sweep, updated ages otherwise.
    always_comb begin
        for (int i = 0; i < WAY_NUM; i++) begin
            lru_write[i] = (r_state == LRU_UPDATE) ? w_new_ages[i] : WAY_NUM_BITS'(i);
        end
    end

    // Reset masks strobes immediately so an update in flight never writes.
    always_comb begin
        lru_index   = r_lru_index;
        lru_req_we  = r_we & ~rst;
        req_ready   = r_ready & ~rst;
        init_done   = r_init_done & ~rst;
        resp_valid  = r_resp_valid & ~rst;
        resp_no_way = r_resp_valid & w_no_way & ~rst;
        resp_way    = (r_resp_valid && !w_no_way && !rst) ? w_way : '0;
    end

endmodule

// File: tb/tb_cache_lru_ctrl.sv
// Bench for cache_lru_ctrl: LRU memory model plus a recency-list reference.
module tb_cache_lru_ctrl;
    import cache_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic [INDEX_BITS-1:0]   req_index;
    logic                    req_hit;
    logic [WAY_NUM_BITS-1:0] req_hit_way;
    logic [WAY_NUM-1:0]      req_way_mask;
    logic                    resp_valid;
    logic [WAY_NUM_BITS-1:0] resp_way;
    logic                    resp_no_way;
    logic                    init_done;
    logic [INDEX_BITS-1:0]   lru_index;
    logic                    lru_req_we;
    logic [WAY_NUM_BITS-1:0] lru_write [0:WAY_NUM-1];
    logic [WAY_NUM_BITS-1:0] lru_read  [0:WAY_NUM-1];

    int n_vec = 0;
    int n_err = 0;

    // LRU age memory seen by the DUT
    logic [WAY_NUM_BITS-1:0] mem [0:CACHE_LINES-1][0:WAY_NUM-1];
    // Reference: per line, ways ordered most- to least-recently used
    int order [0:CACHE_LINES-1][0:WAY_NUM-1];

    cache_lru_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_hit      (req_hit),
        .req_hit_way  (req_hit_way),
        .req_way_mask (req_way_mask),
        .resp_valid   (resp_valid),
        .resp_way     (resp_way),
        .resp_no_way  (resp_no_way),
        .init_done    (init_done),
        .lru_index    (lru_index),
        .lru_req_we   (lru_req_we),
        .lru_write    (lru_write),
        .lru_read     (lru_read)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lru_req_we) begin
            for (int i = 0; i < WAY_NUM; i++) mem[lru_index][i] <= lru_write[i];
        end
    end

    always_comb begin
        for (int i = 0; i < WAY_NUM; i++) lru_read[i] = mem[lru_index][i];
    end

    function automatic void model_reset();
        for (int l = 0; l < CACHE_LINES; l++)
            for (int p = 0; p < WAY_NUM; p++) order[l][p] = p;
    endfunction

    function automatic void model_touch(input int line, input int way);
        int q[$];
        for (int p = 0; p < WAY_NUM; p++)
            if (order[line][p] != way) q.push_back(order[line][p]);
        q.push_front(way);
        for (int p = 0; p < WAY_NUM; p++) order[line][p] = q[p];
    endfunction

    function automatic int model_victim(input int line, input logic [WAY_NUM-1:0] mask);
        for (int p = WAY_NUM - 1; p >= 0; p--)
            if (mask[order[line][p]]) return order[line][p];
        return -1;
    endfunction

    function automatic int model_age(input int line, input int way);
        for (int p = 0; p < WAY_NUM; p++)
            if (order[line][p] == way) return p;
        return -1;
    endfunction

    function automatic logic [7:0] exp_ages(input int line);
        logic [7:0] v;
        for (int w = 0; w < WAY_NUM; w++) v[w*2 +: 2] = 2'(model_age(line, w));
        return v;
    endfunction

    function automatic logic [7:0] ident_ages();
        logic [7:0] v;
        for (int w = 0; w < WAY_NUM; w++) v[w*2 +: 2] = 2'(w);
        return v;
    endfunction

    function automatic logic [7:0] dut_write();
        logic [7:0] v;
        for (int i = 0; i < WAY_NUM; i++) v[i*2 +: 2] = lru_write[i];
        return v;
    endfunction

    function automatic logic [7:0] mem_line(input int line);
        logic [7:0] v;
        for (int i = 0; i < WAY_NUM; i++) v[i*2 +: 2] = mem[line][i];
        return v;
    endfunction

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {lru_req_we, req_ready, resp_valid, resp_no_way, resp_way, init_done};
        n_vec++;
        if (obs !== 7'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 0000000", obs);
        end
    endtask

    task automatic test_reset_mid_init();
        rst = 1'b0;
        repeat (50) @(negedge clk);
        n_vec++;
        if ({lru_req_we, lru_index} !== {1'b1, INDEX_BITS'(49)}) begin
            n_err++;
            $display("FAIL mid_init_progress got we=%b idx=%0d want we=1 idx=49", lru_req_we, lru_index);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({lru_req_we, init_done} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_init_reset got we=%b done=%b want 0 0", lru_req_we, init_done);
        end
    endtask

    // Releases reset and follows the full sweep, one line per cycle.
    task automatic test_init_sweep();
        logic [INDEX_BITS+10:0] obs, exp;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < CACHE_LINES; k++) begin
            @(negedge clk);
            obs = {lru_req_we, req_ready, init_done, lru_index, dut_write()};
            exp = {1'b1, 1'b0, 1'b0, INDEX_BITS'(k), ident_ages()};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL init_write[%0d] got %h want %h", k, obs, exp);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({init_done, req_ready, lru_req_we} !== 3'b110) begin
            n_err++;
            $display("FAIL init_end got done=%b ready=%b we=%b want 1 1 0", init_done, req_ready, lru_req_we);
        end
    endtask

    task automatic do_req(input int idx, input bit hit, input int hw,
                          input logic [WAY_NUM-1:0] mask, input string tag);
        int exp_way;
        bit exp_no;
        bit ok;
        logic [INDEX_BITS+2:0] obs_ctl, exp_ctl;
        logic [7:0] obs_w, exp_w;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s ready_timeout got ready=%b want 1", tag, req_ready);
            return;
        end
        exp_no  = !hit && (mask == '0);
        exp_way = hit ? hw : (exp_no ? 0 : model_victim(idx, mask));
        req_valid    = 1'b1;
        req_index    = INDEX_BITS'(idx);
        req_hit      = hit;
        req_hit_way  = WAY_NUM_BITS'(hw);
        req_way_mask = mask;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        obs_ctl = {resp_valid, resp_no_way, lru_req_we, lru_index};
        exp_ctl = {1'b1, exp_no, !exp_no, INDEX_BITS'(idx)};
        n_vec++;
        if (obs_ctl !== exp_ctl) begin
            n_err++;
            $display("FAIL %s ctl got %h want %h", tag, obs_ctl, exp_ctl);
        end
        n_vec++;
        if (resp_way !== WAY_NUM_BITS'(exp_way)) begin
            n_err++;
            $display("FAIL %s way got %0d want %0d", tag, resp_way, exp_way);
        end
        if (!exp_no) begin
            model_touch(idx, exp_way);
            obs_w = dut_write();
            exp_w = exp_ages(idx);
            n_vec++;
            if (obs_w !== exp_w) begin
                n_err++;
                $display("FAIL %s write got %h want %h", tag, obs_w, exp_w);
            end
        end
    endtask

    task automatic test_directed();
        do_req(5, 1'b1, 2, 4'b0000, "hit_way2");
        do_req(6, 1'b0, 0, 4'b1111, "miss_all");
        do_req(7, 1'b0, 0, 4'b0011, "miss_low2");
        do_req(8, 1'b0, 0, 4'b0000, "miss_empty");
        do_req(CACHE_LINES - 1, 1'b0, 0, 4'b0100, "last_line");
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            do_req(($urandom % 4 == 0) ? int'($urandom_range(CACHE_LINES - 1, 0))
                                       : int'($urandom_range(7, 0)),
                   1'($urandom), int'($urandom_range(3, 0)),
                   4'($urandom), "random");
        end
    endtask

    // Requester holds req_valid; accepts alternate, then reset hits an update.
    task automatic test_back_to_back();
        localparam int IDX = 20;
        localparam logic [3:0] MASK = 4'b1010;
        bit exp_v;
        int v;
        for (int t = 0; t < 20 && req_ready !== 1'b1; t++) @(negedge clk);
        req_valid    = 1'b1;
        req_index    = INDEX_BITS'(IDX);
        req_hit      = 1'b0;
        req_hit_way  = '0;
        req_way_mask = MASK;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_v = (c % 2 == 0);
            n_vec++;
            if ({resp_valid, req_ready} !== {exp_v, !exp_v}) begin
                n_err++;
                $display("FAIL b2b_cycle%0d got valid=%b ready=%b want valid=%b", c, resp_valid, req_ready, exp_v);
            end
            if (exp_v) begin
                v = model_victim(IDX, MASK);
                n_vec++;
                if (resp_way !== WAY_NUM_BITS'(v)) begin
                    n_err++;
                    $display("FAIL b2b_way%0d got %0d want %0d", c, resp_way, v);
                end
                model_touch(IDX, v);
                n_vec++;
                if (dut_write() !== exp_ages(IDX)) begin
                    n_err++;
                    $display("FAIL b2b_write%0d got %h want %h", c, dut_write(), exp_ages(IDX));
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({lru_req_we, resp_valid, resp_way, resp_no_way} !== 5'd0) begin
            n_err++;
            $display("FAIL rst_in_update got we=%b valid=%b way=%0d want 0 0 0", lru_req_we, resp_valid, resp_way);
        end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (mem_line(IDX) !== exp_ages(IDX)) begin
            n_err++;
            $display("FAIL rst_discard got %h want %h", mem_line(IDX), exp_ages(IDX));
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_index    = '0;
        req_hit      = 1'b0;
        req_hit_way  = '0;
        req_way_mask = '0;
        model_reset();
        test_reset();
        test_reset_mid_init();
        test_init_sweep();
        test_directed();
        test_random(300);
        test_back_to_back();
        test_init_sweep();
        test_random(40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
